// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: op encodings, arbiter FSM states and index width.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_FETCH = 2'b01,
    OP_SEND  = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_XFER,
    ST_RELEASE
  } state_e;

  localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/bus_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping.
module rr_select
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  localparam int unsigned SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  int unsigned idx;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % N_REQ;
      if (!valid && req[SEL_W'(idx)]) begin
        valid  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: IDLE -> GRANT -> XFER -> RELEASE with grant timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       op,
  output logic [N_REQ-1:0] grant,
  output logic [2:0]       owner,
  output logic             bus_busy,
  output logic             timeout_err
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               bus_busy_q, bus_busy_d;
  logic               timeout_err_q, timeout_err_d;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_winner;
  logic [IDX_W-1:0]   next_ptr;
  logic               owner_req;
  logic               op_xfer;
  logic               op_end;

  rr_select #(.N_REQ(N_REQ)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (sel_valid),
    .winner (sel_winner)
  );

  // grant_q is one-hot on the owner while in GRANT, so masking gives the owner's req
  assign owner_req = |(req & grant_q);
  assign op_xfer   = (op == OP_FETCH) || (op == OP_SEND);
  assign op_end    = (op == OP_END);
  assign next_ptr  = (sel_winner == IDX_W'(N_REQ - 1)) ? '0 : sel_winner + IDX_W'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          state_d  = ST_GRANT;
          grant_d  = N_REQ'(1) << sel_winner;
          owner_d  = sel_winner;
          rr_ptr_d = next_ptr;
          cnt_d    = '0;
        end
      end
      ST_GRANT: begin
        if (op_xfer) begin
          state_d = ST_XFER;
        end else if (!owner_req) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d       = ST_RELEASE;
          grant_d       = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_XFER: begin
        if (op_end) begin
          state_d = ST_RELEASE;
          grant_d = '0;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    bus_busy_d = (state_d == ST_GRANT) || (state_d == ST_XFER);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      bus_busy_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      rr_ptr_q      <= rr_ptr_d;
      cnt_q         <= cnt_d;
      bus_busy_q    <= bus_busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign bus_busy    = bus_busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus randomized checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [1:0] op;
  logic [3:0] grant;
  logic [2:0] owner;
  logic       bus_busy;
  logic       timeout_err;

  int         total = 0;
  int         bad   = 0;
  int         ptr   = 0;
  logic [3:0] served = '0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .op          (op),
    .grant       (grant),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic [3:0] g, input logic busy, input logic err);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_busy"}, 32'(bus_busy), 32'(busy));
    chk({tag, "_terr"}, 32'(timeout_err), 32'(err));
    chk({tag, "_onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Requester closest to ptr going upward (distance measured modulo N).
  function automatic int pick(input logic [3:0] r, input int p);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        int d = (i - p + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic grant_expect(input string tag, output int w);
    logic [3:0] g;
    w = pick(req, ptr);
    g = 4'(1) << w;
    step;
    bus(tag, g, 1'b1, 1'b0);
    chk({tag, "_owner"}, 32'(owner), 32'(w));
    served |= grant;
    ptr = (w + 1) % N;
  endtask

  initial begin
    logic [3:0] order [5];
    logic [3:0] ob;
    logic [3:0] g;
    int w;
    int kind;
    int k;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset_n = 1'b0;
    req     = '0;
    op      = 2'b00;
    step;
    bus("rst", 4'b0000, 1'b0, 1'b0);
    chk("rst_owner", 32'(owner), 32'd0);
    req = 4'b1111;
    op  = 2'b01;
    step;
    bus("rst_hold", 4'b0000, 1'b0, 1'b0);
    op = 2'b00;

    // Fairness with all four requesting
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      grant_expect($sformatf("fair%0d", i), w);
      chk($sformatf("fair%0d_order", i), 32'(grant), 32'(order[i]));
      op = 2'b01;
      step;
      bus("fair_xfer", order[i], 1'b1, 1'b0);
      op = 2'b11;
      step;
      bus("fair_rel", 4'b0000, 1'b0, 1'b0);
      op = 2'b00;
      step;
      bus("fair_idle", 4'b0000, 1'b0, 1'b0);
    end

    // Single request, END ignored in GRANT, req ignored in XFER
    req = 4'b0001;
    grant_expect("single", w);
    step;
    bus("single_wait", 4'b0001, 1'b1, 1'b0);
    op = 2'b11;
    step;
    bus("single_end_in_grant", 4'b0001, 1'b1, 1'b0);
    op = 2'b01;
    step;
    bus("single_xfer", 4'b0001, 1'b1, 1'b0);
    op  = 2'b00;
    req = 4'b0000;
    step;
    bus("single_xfer_noreq", 4'b0001, 1'b1, 1'b0);
    op = 2'b11;
    step;
    bus("single_rel", 4'b0000, 1'b0, 1'b0);
    chk("single_owner_kept", 32'(owner), 32'd0);
    op = 2'b01;
    step;
    bus("single_idle", 4'b0000, 1'b0, 1'b0);
    op = 2'b00;

    // Timeout: grant visible for TO cycles, then pulse
    req = 4'b0100;
    grant_expect("to", w);
    for (int i = 0; i < TO - 1; i++) begin
      step;
      bus($sformatf("to_hold%0d", i), 4'b0100, 1'b1, 1'b0);
    end
    step;
    bus("to_fire", 4'b0000, 1'b0, 1'b1);
    req = 4'b1001;
    step;
    bus("to_pulse_end", 4'b0000, 1'b0, 1'b0);
    grant_expect("to_rrptr", w);
    chk("to_rrptr_owner3", 32'(owner), 32'd3);

    // Early drop of the owner's request
    step;
    bus("drop_hold", 4'b1000, 1'b1, 1'b0);
    req = 4'b0001;
    step;
    bus("drop", 4'b0000, 1'b0, 1'b0);
    step;
    bus("drop_idle", 4'b0000, 1'b0, 1'b0);
    grant_expect("drop_next", w);

    // Reset during XFER
    op = 2'b01;
    step;
    bus("rx_xfer", 4'b0001, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    bus("rx_async", 4'b0000, 1'b0, 1'b0);
    chk("rx_owner", 32'(owner), 32'd0);
    ptr = 0;
    op  = 2'b00;
    req = 4'b0010;
    @(negedge clk);
    reset_n = 1'b1;
    grant_expect("rx_regrant", w);
    op = 2'b10;
    step;
    bus("rx_xfer2", 4'b0010, 1'b1, 1'b0);
    op = 2'b11;
    step;
    bus("rx_rel", 4'b0000, 1'b0, 1'b0);
    op = 2'b00;
    step;
    bus("rx_idle", 4'b0000, 1'b0, 1'b0);

    // Random transactions; the last few keep every processor requesting
    served = '0;
    for (int t = 0; t < 50; t++) begin
      req = (t >= 46) ? 4'hF : 4'($urandom_range(1, 15));
      grant_expect($sformatf("rnd%0d", t), w);
      ob   = 4'(1) << w;
      g    = ob;
      kind = $urandom_range(0, 3);
      k    = (kind == 3) ? TO - 1 : $urandom_range(0, TO - 2);
      for (int i = 0; i < k; i++) begin
        req = 4'($urandom) | ob;
        step;
        bus("rnd_wait", g, 1'b1, 1'b0);
      end
      if (kind <= 1) begin
        op = (kind == 0) ? 2'b01 : 2'b10;
        step;
        bus("rnd_xfer", g, 1'b1, 1'b0);
        op = 2'b00;
        for (int i = 0; i < $urandom_range(0, 3); i++) begin
          req = 4'($urandom);
          step;
          bus("rnd_xfer_hold", g, 1'b1, 1'b0);
        end
        op = 2'b11;
        step;
        bus("rnd_end", 4'b0000, 1'b0, 1'b0);
      end else if (kind == 2) begin
        req = 4'($urandom) & ~ob;
        step;
        bus("rnd_drop", 4'b0000, 1'b0, 1'b0);
      end else begin
        step;
        bus("rnd_timeout", 4'b0000, 1'b0, 1'b1);
      end
      op = 2'b00;
      step;
      bus("rnd_idle", 4'b0000, 1'b0, 1'b0);
    end
    chk("served_all", 32'(served), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
